// File: rtl/data_sram_responder_if.sv
// Data-RAM port bundle between the CPU-side requester and the memory responder.
// The CPU drives the request fields; the responder drives the handshake and response.
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [2:0]  outstanding;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, outstanding
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, outstanding
    );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-RAM port. Accepts one request per
// edge while the response queue has room, services it against a word-addressed
// RAM on the accepting edge, and answers strictly in order after LATENCY cycles.
module data_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    // Queue storage is sized for the largest legal QDEPTH; pointers only ever
    // visit the first QDEPTH slots.
    localparam int         SLOTS    = 4;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [1:0] PTR_LAST = 2'(QDEPTH - 1);
    localparam logic [2:0] Q_FULL   = 3'(QDEPTH);

    // Word-addressed storage and its registered read port
    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_rdata_q;
    logic [DEPTH_LOG2-1:0] word_idx;

    // Response queue: per-slot payload plus circular-buffer bookkeeping
    logic [SLOTS-1:0] valid_q, valid_d;
    logic             ent_wr_q   [SLOTS];
    logic             ent_wr_d   [SLOTS];
    logic [31:0]      ent_data_q [SLOTS];
    logic [31:0]      ent_data_d [SLOTS];
    logic [3:0]       ent_cnt_q  [SLOTS];
    logic [3:0]       ent_cnt_d  [SLOTS];
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [2:0]       count_q, count_d;

    // A read's RAM word lands in ram_rdata_q on the accepting edge and is
    // copied into its queue slot one edge later; until then the slot is
    // "pending fill" and the head mux bypasses to ram_rdata_q.
    logic             fill_valid_q, fill_valid_d;
    logic [1:0]       fill_ptr_q, fill_ptr_d;

    logic             addr_ok_w;
    logic             data_ok_w;
    logic             push;
    logic             pop;
    logic [31:0]      head_data;
    logic             unused_addr_bits;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Byte offset and address bits above the RAM aliasing range are ignored
    assign word_idx         = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[31:DEPTH_LOG2+2]};

    // Acceptance depends only on registered occupancy: no req->addr_ok path
    // and no credit for a pop happening in the same cycle.
    assign addr_ok_w = (count_q < Q_FULL);
    assign data_ok_w = valid_q[head_q] && (ent_cnt_q[head_q] == 4'd0);
    assign push      = bus.req && addr_ok_w;
    assign pop       = data_ok_w;

    // Byte-masked write and registered read, both taking effect on the accepting edge
    always_ff @(posedge clk) begin
        if (push && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
        if (push && !bus.wr) begin
            ram_rdata_q <= mem[word_idx];
        end
    end

    // Next-state for the queue: countdown, fill, pop at head, push at tail
    always_comb begin
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_valid_d = 1'b0;
        fill_ptr_d   = fill_ptr_q;
        for (int i = 0; i < SLOTS; i++) begin
            ent_wr_d[i]   = ent_wr_q[i];
            ent_data_d[i] = ent_data_q[i];
            ent_cnt_d[i]  = (valid_q[i] && (ent_cnt_q[i] != 4'd0)) ? (ent_cnt_q[i] - 4'd1)
                                                                   : ent_cnt_q[i];
        end

        if (fill_valid_q) begin
            ent_data_d[fill_ptr_q] = ram_rdata_q;
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end

        // The tail slot can never be the head being popped or the slot being
        // filled: push is only allowed below full, and a slot is filled on the
        // edge right after it was pushed.
        if (push) begin
            valid_d[tail_q]    = 1'b1;
            ent_wr_d[tail_q]   = bus.wr;
            ent_data_d[tail_q] = 32'd0;
            ent_cnt_d[tail_q]  = CNT_INIT;
            tail_d             = ptr_inc(tail_q);
            if (!bus.wr) begin
                fill_valid_d = 1'b1;
                fill_ptr_d   = tail_q;
            end
        end

        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Queue control state; reset drops every in-flight request silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fill_valid_q <= 1'b0;
            fill_ptr_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fill_valid_q <= fill_valid_d;
            fill_ptr_q   <= fill_ptr_d;
        end
    end

    // Slot payloads carry no meaning while their valid bit is clear, so they need no reset
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        // Per-slot payload registers
        always_ff @(posedge clk) begin
            ent_wr_q[gi]   <= ent_wr_d[gi];
            ent_data_q[gi] <= ent_data_d[gi];
            ent_cnt_q[gi]  <= ent_cnt_d[gi];
        end
    end

    // Head read data, bypassing to the RAM output while the head is still pending fill
    always_comb begin
        head_data = ent_data_q[head_q];
        if (fill_valid_q && (fill_ptr_q == head_q)) begin
            head_data = ram_rdata_q;
        end
    end

    assign bus.addr_ok     = addr_ok_w;
    assign bus.data_ok     = data_ok_w;
    assign bus.rdata       = (data_ok_w && !ent_wr_q[head_q]) ? head_data : 32'd0;
    assign bus.outstanding = count_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: four responder configurations share one stimulus stream;
// each has a response-queue model (due-cycle based) checked every cycle, and
// directed phases pin the model with hand-computed expectations.
module tb_data_sram_responder;
    logic        clk;
    logic        reset;
    logic        s_req;
    logic        s_wr;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A5A_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Config table: 0:(LAT2,Q2) 1:(LAT3,Q2) 2:(LAT1,Q2) 3:(LAT4,Q3)
    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int L = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 1 : 4;
        localparam int Q = (gi == 3) ? 3 : 2;

        data_sram_responder_if bus ();
        assign bus.req   = s_req;
        assign bus.wr    = s_wr;
        assign bus.wstrb = s_wstrb;
        assign bus.addr  = s_addr;
        assign bus.wdata = s_wdata;

        data_sram_responder #(
            .DEPTH_LOG2(10),
            .LATENCY   (L),
            .QDEPTH    (Q)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );

        resp_t       mq[$];
        logic [31:0] mram [1024];
        int          cyc = 0;

        // Model: a response is due exactly L cycles after its accepting cycle
        always @(negedge clk) begin
            int          occ;
            logic        e_dk;
            logic [31:0] e_rd;
            logic [9:0]  widx;
            resp_t       ent;
            if (reset) mq.delete();
            occ  = mq.size();
            e_dk = 1'b0;
            if (occ > 0) e_dk = (mq[0].due == cyc);
            e_rd = e_dk ? mq[0].data : 32'd0;
            chk($sformatf("cfg%0d addr_ok c%0d", gi, cyc), 32'(bus.addr_ok), 32'(occ < Q));
            chk($sformatf("cfg%0d outstanding c%0d", gi, cyc), 32'(bus.outstanding), 32'(occ));
            chk($sformatf("cfg%0d data_ok c%0d", gi, cyc), 32'(bus.data_ok), 32'(e_dk));
            chk($sformatf("cfg%0d rdata c%0d", gi, cyc), bus.rdata, e_rd);
            if (!reset) begin
                if (e_dk) void'(mq.pop_front());
                if (s_req && (occ < Q)) begin
                    widx    = s_addr[11:2];
                    ent.due = cyc + L;
                    if (s_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) mram[widx][8*b +: 8] = s_wdata[8*b +: 8];
                        ent.data = 32'd0;
                    end else begin
                        ent.data = mram[widx];
                    end
                    mq.push_back(ent);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        s_req   = 1'b1;
        s_wr    = w;
        s_wstrb = st;
        s_addr  = a;
        s_wdata = d;
    endtask

    // One isolated request; watches cfg0 for its response within a bounded window
    task automatic single(input logic w, input logic [3:0] st, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat,
                          output int pulses);
        drive(w, st, a, d);
        tick();
        s_req  = 1'b0;
        lat    = -1;
        pulses = 0;
        rd     = 32'hxxxx_xxxx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (g_cfg[0].bus.data_ok) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    rd  = g_cfg[0].bus.rdata;
                end
            end
            tick();
        end
        $display("[TB] %s addr=0x%08h wstrb=%b wdata=0x%08h -> latency %0d rdata=0x%08h",
                 w ? "write" : "read ", a, st, d, lat, rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          pulses;
        int          acc;
        int          nrd;
        int          max_occ;
        logic [9:0]  ao_seen;
        logic [9:0]  dk_seen;
        logic [31:0] rd_seen [8];

        reset = 1'b1;
        s_req = 1'b0; s_wr = 1'b0; s_wstrb = 4'h0; s_addr = 32'h0; s_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // Fill words 0..31 so every later read has known contents
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 4'hF, 32'(i) * 32'd4, init_val(i));
            tick();
            s_req = 1'b0;
            repeat (4) tick();
        end

        // Async reset mid-cycle with a read in flight
        drive(1'b0, 4'h0, 32'h14, 32'h0);
        tick();
        s_req = 1'b0;
        #2;
        chk("rst pre outstanding", 32'(g_cfg[0].bus.outstanding), 32'd1);
        chk("rst pre lat1 data_ok", 32'(g_cfg[2].bus.data_ok), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst data_ok", 32'(g_cfg[0].bus.data_ok), 32'd0);
        chk("rst rdata", g_cfg[2].bus.rdata, 32'd0);
        chk("rst lat1 data_ok", 32'(g_cfg[2].bus.data_ok), 32'd0);
        chk("rst outstanding", 32'(g_cfg[0].bus.outstanding), 32'd0);
        chk("rst addr_ok", 32'(g_cfg[0].bus.addr_ok), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (g_cfg[0].bus.data_ok || g_cfg[1].bus.data_ok || g_cfg[3].bus.data_ok) pulses++;
            tick();
        end
        chk("rst no stale response", 32'(pulses), 32'd0);
        $display("[TB] reset with outstanding read done");

        // Write then read back-to-back (cfg0, LATENCY=2)
        drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_rd c0 data_ok", 32'(g_cfg[0].bus.data_ok), 32'd0);
        tick();
        drive(1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("wr_rd c1 outstanding", 32'(g_cfg[0].bus.outstanding), 32'd1);
        tick();
        s_req = 1'b0;
        @(negedge clk);
        chk("wr_rd c2 data_ok", 32'(g_cfg[0].bus.data_ok), 32'd1);
        chk("wr_rd c2 rdata", g_cfg[0].bus.rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("wr_rd c3 data_ok", 32'(g_cfg[0].bus.data_ok), 32'd1);
        chk("wr_rd c3 rdata", g_cfg[0].bus.rdata, 32'hDEAD_BEEF);
        tick();
        repeat (6) tick();
        $display("[TB] write 0x10 then read 0x10 done");

        // Byte strobes and the empty-strobe write
        single(1'b1, 4'hF, 32'h20, 32'h1122_3344, rd, lat, pulses);
        chk("strb full write latency", 32'(lat), 32'd2);
        single(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, rd, lat, pulses);
        chk("strb partial write rdata", rd, 32'd0);
        single(1'b0, 4'h0, 32'h20, 32'h0, rd, lat, pulses);
        chk("strb merged rdata", rd, 32'h11BB_33DD);
        single(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, rd, lat, pulses);
        chk("strb0 pulses", 32'(pulses), 32'd1);
        single(1'b0, 4'h0, 32'h20, 32'h0, rd, lat, pulses);
        chk("strb0 word unchanged", rd, 32'h11BB_33DD);

        // Full queue on cfg1 (LATENCY=3, QDEPTH=2): req held until 4 reads accepted
        acc = 0; nrd = 0; max_occ = 0; ao_seen = '0; dk_seen = '0;
        for (int c = 0; c < 10; c++) begin
            s_req   = (acc < 4);
            s_wr    = 1'b0;
            s_wstrb = 4'h0;
            s_addr  = 32'h40 + 32'(acc) * 32'd4;
            @(negedge clk);
            ao_seen[c] = g_cfg[1].bus.addr_ok;
            dk_seen[c] = g_cfg[1].bus.data_ok;
            if (int'(g_cfg[1].bus.outstanding) > max_occ) max_occ = int'(g_cfg[1].bus.outstanding);
            if (g_cfg[1].bus.data_ok) begin
                if (nrd < 4) rd_seen[nrd] = g_cfg[1].bus.rdata;
                nrd++;
            end
            if (s_req && g_cfg[1].bus.addr_ok) acc++;
            tick();
        end
        s_req = 1'b0;
        chk("full addr_ok pattern", 32'(ao_seen), 32'(10'b1100110011));
        chk("full data_ok pattern", 32'(dk_seen), 32'(10'b0110011000));
        chk("full max outstanding", 32'(max_occ), 32'd2);
        chk("full response count", 32'(nrd), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("full rdata %0d", k), rd_seen[k], init_val(16 + k));
        repeat (6) tick();
        $display("[TB] full-queue read burst done");

        // Streaming on cfg2 (LATENCY=1): 8 back-to-back reads of words 0..7
        dk_seen = '0; nrd = 0;
        for (int c = 0; c < 10; c++) begin
            s_req   = (c < 8);
            s_wr    = 1'b0;
            s_wstrb = 4'h0;
            s_addr  = 32'(c) * 32'd4;
            @(negedge clk);
            dk_seen[c] = g_cfg[2].bus.data_ok;
            if (g_cfg[2].bus.data_ok) begin
                if (nrd < 8) rd_seen[nrd] = g_cfg[2].bus.rdata;
                nrd++;
            end
            tick();
        end
        s_req = 1'b0;
        chk("stream data_ok pattern", 32'(dk_seen), 32'(10'b0111111110));
        for (int k = 0; k < 8; k++)
            chk($sformatf("stream rdata %0d", k), rd_seen[k], (k == 4) ? 32'hDEAD_BEEF : init_val(k));
        repeat (6) tick();
        $display("[TB] streaming read burst done");

        // Address aliasing: upper and byte-offset bits are ignored
        single(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D, rd, lat, pulses);
        single(1'b0, 4'h0, 32'h0000_0003, 32'h0, rd, lat, pulses);
        chk("alias low read", rd, 32'hCAFE_F00D);
        single(1'b0, 4'h0, 32'hFFFF_F000, 32'h0, rd, lat, pulses);
        chk("alias high read", rd, 32'hCAFE_F00D);

        // Random traffic against the models, with one async reset in the middle
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                s_req = 1'b0;
                #2 reset = 1'b1;
                @(posedge clk);
                #3 reset = 1'b0;
                tick();
            end
            s_req   = ($urandom_range(0, 9) < 7);
            s_wr    = 1'($urandom_range(0, 1));
            s_wstrb = 4'($urandom);
            s_addr  = $urandom & 32'hFFFF_F07F;
            s_wdata = $urandom;
            tick();
        end
        s_req = 1'b0;
        repeat (10) tick();
        $display("[TB] random traffic done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
